// File: rtl/rsa_pkg.sv
// Shared FSM type and default sizing for the streaming RSA decryptor.
package rsa_pkg;
  localparam int ARQ_DEFAULT  = 16;
  localparam int ADDR_DEFAULT = 17;

  // Cycles from the ADDR cycle of a word to its out_valid rising.
  localparam int WORD_LATENCY = ARQ_DEFAULT * ARQ_DEFAULT + ARQ_DEFAULT + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_REDUCE,
    S_EXP,
    S_OUT,
    S_FIN
  } state_t;
endpackage

// File: rtl/mod_mult.sv
// Interleaved MSB-first shift-add modular multiplier: prod = a*b mod n,
// rdy pulses exactly ARQ cycles after go. Requires b < n; a is unrestricted.
module mod_mult #(
  parameter int ARQ = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_go,
  input  logic [ARQ-1:0] i_a,
  input  logic [ARQ-1:0] i_b,
  input  logic [ARQ-1:0] i_n,
  output logic [ARQ-1:0] o_prod,
  output logic           o_rdy
);
  localparam int CW = $clog2(ARQ + 1);

  logic [ARQ-1:0] r_acc, r_a, r_b, r_n;
  logic [CW-1:0]  r_cnt;
  logic           r_busy, r_rdy;
  logic [ARQ-1:0] w_step;

  // One bit of the interleave; one extra bit of headroom keeps 2R and R+b exact.
  function automatic logic [ARQ-1:0] mod_step(input logic [ARQ-1:0] acc, input logic abit,
                                              input logic [ARQ-1:0] b, input logic [ARQ-1:0] n);
    logic [ARQ:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    if (abit) t = t + {1'b0, b};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    return t[ARQ-1:0];
  endfunction

  // The go cycle already performs the first step straight from the inputs.
  always_comb begin
    if (i_go) w_step = mod_step('0, i_a[ARQ-1], i_b, i_n);
    else      w_step = mod_step(r_acc, r_a[ARQ-1], r_b, r_n);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_rdy  <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (i_go) begin
        r_acc  <= w_step;
        r_a    <= i_a << 1;
        r_b    <= i_b;
        r_n    <= i_n;
        r_cnt  <= CW'(ARQ - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_step;
        r_a   <= r_a << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_rdy  <= 1'b1;
        end
      end
    end
  end

  assign o_prod = r_acc;
  assign o_rdy  = r_rdy;
endmodule

// File: rtl/rsa_modex_stream.sv
// Batch RSA decryptor: walks ciphertext memory and streams c^d mod n per word
// over a valid/ready port with a fixed, data-independent latency.
module rsa_modex_stream
  import rsa_pkg::*;
#(
  parameter int ARQ  = ARQ_DEFAULT,
  parameter int ADDR = ADDR_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [ADDR-1:0] i_base_addr,
  input  logic [ADDR-1:0] i_count,
  input  logic [ARQ-1:0]  i_exp_key,
  input  logic [ARQ-1:0]  i_modulus,
  output logic [ADDR-1:0] o_mem_addr,
  input  logic [ARQ-1:0]  i_mem_rdata,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [ARQ-1:0]  o_out_data,
  output logic [ADDR-1:0] o_out_index,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);
  localparam int BW = (ARQ > 1) ? $clog2(ARQ) : 1;

  state_t          r_state, w_state_next;
  logic [ADDR-1:0] r_base_addr, r_count, r_idx, w_idx_inc;
  logic [ARQ-1:0]  r_exp, r_mod, r_result;
  logic [BW-1:0]   r_bit;
  logic            r_err;

  logic            w_mul_go, w_sq_go, w_mul_rdy, w_sq_rdy, w_iter_rdy, w_last_bit;
  logic [ARQ-1:0]  w_mul_a, w_mul_b, w_sq_a, w_prod_mul, w_prod_sq, w_new_result;

  mod_mult #(.ARQ(ARQ)) u_mul (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(w_mul_go), .i_a(w_mul_a), .i_b(w_mul_b),
    .i_n(r_mod), .o_prod(w_prod_mul), .o_rdy(w_mul_rdy)
  );

  mod_mult #(.ARQ(ARQ)) u_sq (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(w_sq_go), .i_a(w_sq_a), .i_b(w_sq_a),
    .i_n(r_mod), .o_prod(w_prod_sq), .o_rdy(w_sq_rdy)
  );

  assign w_idx_inc    = r_idx + 1'b1;
  assign w_iter_rdy   = w_mul_rdy & w_sq_rdy;
  assign w_last_bit   = (r_bit == BW'(ARQ - 1));
  assign w_new_result = r_exp[r_bit] ? w_prod_mul : r_result;

  // Next iteration is launched in the rdy cycle from the fresh products, so no gaps.
  always_comb begin
    w_state_next = r_state;
    w_mul_go     = 1'b0;
    w_sq_go      = 1'b0;
    w_mul_a      = w_new_result;
    w_mul_b      = w_prod_sq;
    w_sq_a       = w_prod_sq;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_modulus < ARQ'(2) || i_count == '0) w_state_next = S_FIN;
          else                                      w_state_next = S_ADDR;
        end
      end
      S_ADDR: w_state_next = S_CAPT;
      S_CAPT: begin
        w_mul_go     = 1'b1;
        w_mul_a      = i_mem_rdata;
        w_mul_b      = ARQ'(1);
        w_state_next = S_REDUCE;
      end
      S_REDUCE: begin
        if (w_mul_rdy) begin
          w_mul_go     = 1'b1;
          w_sq_go      = 1'b1;
          w_mul_a      = ARQ'(1);
          w_mul_b      = w_prod_mul;
          w_sq_a       = w_prod_mul;
          w_state_next = S_EXP;
        end
      end
      S_EXP: begin
        if (w_iter_rdy) begin
          if (w_last_bit) begin
            w_state_next = S_OUT;
          end else begin
            w_mul_go = 1'b1;
            w_sq_go  = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (i_out_ready) w_state_next = (w_idx_inc < r_count) ? S_ADDR : S_FIN;
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_base_addr <= '0;
      r_count     <= '0;
      r_exp       <= '0;
      r_mod       <= '0;
      r_idx       <= '0;
      r_result    <= '0;
      r_bit       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base_addr <= i_base_addr;
            r_count     <= i_count;
            r_exp       <= i_exp_key;
            r_mod       <= i_modulus;
            r_idx       <= '0;
            r_err       <= (i_modulus < ARQ'(2));
          end
        end
        S_REDUCE: begin
          if (w_mul_rdy) begin
            r_result <= ARQ'(1);
            r_bit    <= '0;
          end
        end
        S_EXP: begin
          if (w_iter_rdy) begin
            r_result <= w_new_result;
            r_bit    <= r_bit + 1'b1;
          end
        end
        S_OUT: begin
          if (i_out_ready) r_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr  = (r_state == S_ADDR) ? r_base_addr + r_idx : '0;
  assign o_out_valid = (r_state == S_OUT);
  assign o_out_data  = r_result;
  assign o_out_index = r_idx;
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_FIN);
  assign o_done      = (r_state == S_FIN);
  assign o_err       = r_err;
endmodule

// File: doc/rsa_modex_stream.md
Name: rsa_modex_stream

Overview:
- Parametrised successor of the fixed-key RSA decrypt path: walks a range of ciphertext memory and decrypts each word by constant-time modular exponentiation.
- Streams each plaintext out on a valid/ready interface.
- Exponent and modulus are runtime inputs latched at start, not constants. Word width and address width are parameters.
- Sits between the ciphertext memory and the display/consumer logic.

Parameters:
ARQ, 16, data/key/modulus width in bits
ADDR, 17, memory address width in bits

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  launch a batch; ignored while busy
base_addr  in  ADDR  first ciphertext address
count  in  ADDR  number of words to decrypt
exp_key  in  ARQ  private exponent d
modulus  in  ARQ  modulus n
mem_addr  out  ADDR  read address to ciphertext memory
mem_rdata  in  ARQ  read data, valid one cycle after mem_addr
out_valid  out  1  plaintext available
out_ready  in  1  consumer accepts plaintext
out_data  out  ARQ  plaintext m = c^d mod n
out_index  out  ADDR  word offset 0..count-1 of out_data
busy  out  1  batch in progress
done  out  1  one-cycle pulse at batch end
err  out  1  batch rejected because modulus < 2; held until the next start

Behaviour:
- Reset: asynchronous, active-high. Every output is 0, the FSM is in IDLE, and any in-flight batch is abandoned with no done pulse.
- Start in IDLE:
  - Latch base_addr, count, exp_key and modulus.
  - Clear err. Set busy on the next cycle.
  - If modulus < 2: set err, pulse done, stay IDLE, busy stays 0.
  - If count = 0: pulse done, no out_valid.
- FSM states: IDLE -> ADDR -> CAPT -> REDUCE -> EXP -> OUT -> (ADDR | FIN) -> IDLE.
- ADDR (1 cycle): mem_addr = base_addr + i, modulo 2^ADDR (wraps silently). i is the word offset.
- CAPT (1 cycle): register mem_rdata as c.
- REDUCE (ARQ cycles): base = c*1 mod n using the multiplier. This handles c >= n.
- EXP: result = 1, then ARQ iterations scanning exp_key from LSB to MSB.
  - Each iteration launches both multiplier instances in parallel for exactly ARQ cycles: result*base mod n and base*base mod n.
  - result takes the product only if the key bit is 1; base always takes the square.
  - All ARQ bits are processed regardless of leading zeros. No idle cycles between iterations.
- Fixed latency: out_valid first rises exactly ARQ*ARQ + ARQ + 2 cycles after the ADDR cycle (274 for ARQ=16). It does not depend on data or key.
- OUT:
  - Hold out_valid, out_data and out_index stable until out_valid && out_ready.
  - The handshake cycle increments i. The next cycle is ADDR if i < count, else FIN.
  - out_ready high on the first valid cycle costs no extra cycles.
- FIN (1 cycle): done = 1, busy = 0, return to IDLE.
- Arithmetic:
  - Multiplier is interleaved MSB-first shift-add. Each step computes R = 2R mod n, then R = R + a_bit*b mod n, using one conditional subtract per half-step.
  - Internal width is ARQ+1 bits so no overflow. Operand b must be < n; a may be any ARQ-bit value.
  - exp_key = 0 yields 1 for every word.
- Input changes while busy have no effect. start while busy is ignored.

Decomposition:
- Package rsa_pkg:
  - FSM state enum.
  - Default ARQ/ADDR.
  - Localparam for per-word latency, ARQ*ARQ+ARQ+2.
- Sub-module mod_mult #(ARQ): ports clk, rst, go, a, b, n, prod, rdy.
  - Exactly ARQ cycles from go to rdy (1-cycle pulse).
  - prod is held until the next go.
  - Instantiated twice: multiply and square. The multiply instance is also used for REDUCE.

Test Plan:
- Textbook key: n=3233, d=2753, ARQ=16, base_addr=0x00010, count=1, memory[0x10]=2790, out_ready=1 -> out_data=65, out_index=0; out_valid rises 274 cycles after ADDR; then done pulses once and busy falls.
- Reduction path: memory word 65535, exp_key=1, n=3233 -> out_data=875. With exp_key=0 -> out_data=1.
- Batch with backpressure: count=3 at base_addr=0x1FFFF (addresses wrap to 0x00000, 0x00001), out_ready low for 10 cycles on word 1 -> out_data/out_index held stable; three handshakes with indices 0,1,2; one done pulse.
- Bad inputs: modulus=1 -> err=1, done pulse, no out_valid, busy stays 0. count=0 -> done pulse, err=0, no memory reads.
- Reset mid-EXP: assert rst 100 cycles into word 0 -> all outputs 0 immediately, no done pulse; a new start then completes normally.
- start while busy with different modulus -> ignored; results match the originally latched key.
